serial_subtractor: RTL and testbench

//  Bit-serial WIDTH-bit subtractor: computes A - B - bin one bit per clock, LSB first,

---
 rtl/serial_subtractor.sv | 141 ++++++++++++++
 tb/tb_serial_subtractor.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (A - B - bin, LSB first) with valid/ready on both sides.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] difference,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             borrow;
    logic [CW-1:0]    cnt;

    logic             d_bit;
    logic             borrow_next;
    logic             last_bit;

    // Single full-subtractor cell: returns {borrow_out, difference_bit}.
    function automatic logic [1:0] full_sub(input logic x, input logic y, input logic br);
        logic d;
        logic bo;
        d  = x ^ y ^ br;
        bo = (~x & y) | (~(x ^ y) & br);
        return {bo, d};
    endfunction

    assign {borrow_next, d_bit} = full_sub(a_sh[0], b_sh[0], borrow);
    assign last_bit = (state == RUN) && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Result bits enter res_sh from the MSB side so the LSB lands at bit 0 after WIDTH shifts;
    // the visible result only updates on DONE entry so it stays stable through IDLE/RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh       <= '0;
            b_sh       <= '0;
            res_sh     <= '0;
            borrow     <= 1'b0;
            cnt        <= '0;
            difference <= '0;
            bout       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        borrow <= bin;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= {d_bit, res_sh[WIDTH-1:1]};
                    borrow <= borrow_next;
                    cnt    <= cnt + CW'(1);
                    if (last_bit) begin
                        difference <= {d_bit, res_sh[WIDTH-1:1]};
                        bout       <= borrow_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    // Signed overflow: borrow into the MSB differs from borrow out of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (last_bit) begin
            ovf <= borrow ^ borrow_next;
        end
    end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8) with an expected-result queue scoreboard.
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] difference;
    logic             bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .bin        (bin),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .difference (difference),
        .bout       (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf        (ovf)
`endif
    );

    typedef struct packed {
        logic [WIDTH-1:0] diff;
        logic             bo;
        logic             ov;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic bi);
        exp_t        e;
        logic [WIDTH:0] r;
        int          s;
        r = {1'b0, x} - {1'b0, y} - {{WIDTH{1'b0}}, bi};
        s = int'($signed(x)) - int'($signed(y)) - int'(bi);
        e.diff = r[WIDTH-1:0];
        e.bo   = r[WIDTH];
        e.ov   = (s > 127) || (s < -128);
        return e;
    endfunction

    task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                          input logic bi, input int stall);
        int               edges;
        logic [WIDTH-1:0] held_d;
        logic             held_b;
        exp_t             e;
        @(negedge clk);
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a        = x;
        b        = y;
        bin      = bi;
        sb_q.push_back(model(x, y, bi));
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        in_valid = 1'b0;
        a        = 8'($urandom);
        b        = 8'($urandom);
        bin      = 1'($urandom);
        while (!out_valid && edges < 50) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check("latency_edges", 32'(edges), 32'(WIDTH + 1));
        held_d = difference;
        held_b = bout;
        for (int i = 0; i < stall; i++) begin
            in_valid = (i % 2 == 0);
            a        = 8'($urandom);
            b        = 8'($urandom);
            @(posedge clk);
            @(negedge clk);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_diff_stable", 32'(difference), 32'(held_d));
            check("stall_bout_stable", 32'(bout), 32'(held_b));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (sb_q.size() == 0) begin
            check("scoreboard_nonempty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check("difference", 32'(difference), 32'(e.diff));
            check("bout", 32'(bout), 32'(e.bo));
`ifdef SERIAL_SUB_OVF_EN
            check("ovf", 32'(ovf), 32'(e.ov));
`endif
        end
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("release_out_valid", 32'(out_valid), 32'd0);
        check("release_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        #12;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_difference", 32'(difference), 32'd0);
        check("reset_bout", 32'(bout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(8'h05, 8'h03, 1'b0, 0);
        run_op(8'h03, 8'h05, 1'b0, 2);
        run_op(8'h00, 8'h00, 1'b1, 0);
        run_op(8'hFF, 8'hFF, 1'b0, 20);
        run_op(8'h80, 8'h01, 1'b0, 1);
        run_op(8'h10, 8'h01, 1'b0, 0);
        run_op(8'hA5, 8'h5A, 1'b1, 3);
        run_op(8'h7F, 8'h80, 1'b0, 0);

        // Abort an operation with reset during RUN cycle 4.
        @(negedge clk);
        in_valid = 1'b1;
        a        = 8'h55;
        b        = 8'h22;
        bin      = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_difference", 32'(difference), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(8'h3C, 8'h0F, 1'b1, 1);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
